// File: rtl/seq_shift_window.sv
// ============================================================================
// seq_shift_window : packed-symbol window with block append, variable shift,
//                    and stall-deferred shift catch-up.   Rev 1.0
// ============================================================================
`default_nettype none

module seq_shift_window #(
  parameter int DATA_W    = 512,
  parameter int SYM_W     = 2,
  parameter int TAIL_SYMS = 11,
  parameter int MAX_SHIFT = 4,
  parameter int CNT_W     = 9,
  localparam int AMT_W    = $clog2(MAX_SHIFT + 1),
  localparam int AV_W     = $clog2(DATA_W / SYM_W + TAIL_SYMS + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              shift_req,
  input  logic [AMT_W-1:0]  shift_amt,
  input  logic              stall,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic [AV_W-1:0]   avail,
  output logic [CNT_W-1:0]  pend_cnt,
  output logic              underflow,
  output logic              pend_ovf
);

  localparam int DATA_SYMS = DATA_W / SYM_W;
  localparam int REG_SYMS  = DATA_SYMS + TAIL_SYMS;
  localparam int WIN_W     = REG_SYMS * SYM_W;
  localparam int SUM_W     = CNT_W + 1;

  localparam logic [AV_W-1:0]  TAIL_AV  = AV_W'(TAIL_SYMS);
  localparam logic [AV_W-1:0]  DATA_AV  = AV_W'(DATA_SYMS);
  localparam logic [CNT_W-1:0] MAXS_CNT = CNT_W'(MAX_SHIFT);
  localparam logic [CNT_W-1:0] PEND_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_HOLD    = 2'd1,
    ST_CATCHUP = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [WIN_W-1:0]  win_q, win_d;
  logic [AV_W-1:0]   avail_q, avail_d;
  logic [CNT_W-1:0]  pend_q, pend_d;
  logic              underflow_q, underflow_d;
  logic              ovf_q, ovf_d;

  logic              w_run;
  logic              w_cu;
  logic [AMT_W-1:0]  w_live;
  logic [AMT_W-1:0]  w_cu_amt;
  logic [AMT_W-1:0]  w_amt;
  logic [AMT_W-1:0]  w_pend_dec;
  logic              w_uf;
  logic [WIN_W-1:0]  w_win_sh;
  logic [AV_W-1:0]   w_av_sh;
  logic              w_load;
  logic [SUM_W-1:0]  w_pend_sum;
  logic              w_pend_sat;
  logic [CNT_W-1:0]  w_pend_nx;

  // Stall gates behaviour in the same cycle, so RUN/CATCHUP act as HOLD while it is high.
  assign w_run = (state_q == ST_RUN) && !stall;
  assign w_cu  = (state_q == ST_CATCHUP) && !stall;

  assign in_ready  = w_run && (avail_q <= TAIL_AV);
  assign out_valid = w_run && (avail_q >= DATA_AV);

  assign w_live   = shift_req ? shift_amt : '0;
  assign w_cu_amt = (pend_q > MAXS_CNT) ? AMT_W'(MAX_SHIFT) : pend_q[AMT_W-1:0];
  assign w_amt    = w_cu ? w_cu_amt : (w_run ? w_live : '0);

  assign w_uf     = AV_W'(w_amt) > avail_q;
  assign w_win_sh = w_uf ? '0 : (win_q >> (32'(w_amt) * SYM_W));
  assign w_av_sh  = w_uf ? '0 : (avail_q - AV_W'(w_amt));
  assign w_load   = in_valid && in_ready;

  // Live shifts outside RUN join the backlog behind the deferred ones.
  assign w_pend_dec = w_cu ? w_cu_amt : '0;
  assign w_pend_sum = {1'b0, pend_q} - SUM_W'(w_pend_dec) + SUM_W'(w_live);
  assign w_pend_sat = w_pend_sum > SUM_W'(PEND_MAX);
  assign w_pend_nx  = w_pend_sat ? PEND_MAX : w_pend_sum[CNT_W-1:0];

  always_comb begin
    state_d     = state_q;
    win_d       = win_q;
    avail_d     = avail_q;
    pend_d      = pend_q;
    underflow_d = 1'b0;
    ovf_d       = ovf_q;

    if (w_run || w_cu) begin
      win_d       = w_win_sh;
      avail_d     = w_av_sh;
      underflow_d = w_uf;
    end

    if (w_load) begin
      win_d   = w_win_sh | (WIN_W'(in_data) << (32'(w_av_sh) * SYM_W));
      avail_d = w_av_sh + DATA_AV;
    end

    if (!w_run) begin
      pend_d = w_pend_nx;
      ovf_d  = ovf_q | w_pend_sat;
    end

    case (state_q)
      ST_RUN: begin
        if (stall) state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (!stall) state_d = (w_pend_nx == '0) ? ST_RUN : ST_CATCHUP;
      end
      ST_CATCHUP: begin
        if (stall)                  state_d = ST_HOLD;
        else if (w_pend_nx == '0)   state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_RUN;
      win_q       <= '0;
      avail_q     <= '0;
      pend_q      <= '0;
      underflow_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      win_q       <= win_d;
      avail_q     <= avail_d;
      pend_q      <= pend_d;
      underflow_q <= underflow_d;
      ovf_q       <= ovf_d;
    end
  end

  assign out_data  = win_q[DATA_W-1:0];
  assign avail     = avail_q;
  assign pend_cnt  = pend_q;
  assign underflow = underflow_q;
  assign pend_ovf  = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_seq_shift_window.sv
// ============================================================================
// tb_seq_shift_window : directed scenarios plus randomized run against a
//                       symbol-queue reference model.   Rev 1.0
// ============================================================================
`default_nettype none

module tb_seq_shift_window;

  localparam int DATA_W    = 512;
  localparam int SYM_W     = 2;
  localparam int TAIL_SYMS = 11;
  localparam int MAX_SHIFT = 4;
  localparam int CNT_W     = 9;
  localparam int AMT_W     = 3;
  localparam int AV_W      = 9;
  localparam int DATA_SYMS = DATA_W / SYM_W;
  localparam int PEND_LIM  = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic              shift_req = 1'b0;
  logic [AMT_W-1:0]  shift_amt = '0;
  logic              stall = 1'b0;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic [AV_W-1:0]   avail;
  logic [CNT_W-1:0]  pend_cnt;
  logic              underflow;
  logic              pend_ovf;

  int n_checks = 0;
  int n_errors = 0;

  seq_shift_window #(
    .DATA_W(DATA_W), .SYM_W(SYM_W), .TAIL_SYMS(TAIL_SYMS),
    .MAX_SHIFT(MAX_SHIFT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .shift_req(shift_req), .shift_amt(shift_amt),
    .stall(stall), .out_data(out_data), .out_valid(out_valid),
    .avail(avail), .pend_cnt(pend_cnt), .underflow(underflow),
    .pend_ovf(pend_ovf)
  );

  always #5 clk = ~clk;

  // Reference model: the window is a queue of symbols, index 0 is the oldest.
  int unsigned q[$];
  int          m_mode;   // 0 running, 1 held, 2 replaying backlog
  int          m_pend;
  bit          m_uf;
  bit          m_ovf;

  task automatic model_reset();
    q.delete();
    m_mode = 0;
    m_pend = 0;
    m_uf   = 1'b0;
    m_ovf  = 1'b0;
  endtask

  task automatic consume(input int n);
    if (n > q.size()) begin
      q.delete();
      m_uf = 1'b1;
    end else begin
      repeat (n) void'(q.pop_front());
    end
  endtask

  function automatic int add_sat(input int v);
    if (v > PEND_LIM) begin
      m_ovf = 1'b1;
      return PEND_LIM;
    end
    return v;
  endfunction

  task automatic model_step();
    int  live;
    int  a;
    bit  rdy;
    live = shift_req ? int'(shift_amt) : 0;
    m_uf = 1'b0;
    if (stall || m_mode == 1) begin
      m_pend = add_sat(m_pend + live);
      if (stall) m_mode = 1;
      else       m_mode = (m_pend == 0) ? 0 : 2;
    end else if (m_mode == 0) begin
      rdy = (q.size() <= TAIL_SYMS);
      if (shift_req) consume(int'(shift_amt));
      if (in_valid && rdy)
        for (int i = 0; i < DATA_SYMS; i++) q.push_back(int'(in_data[SYM_W*i +: SYM_W]));
    end else begin
      a = (m_pend < MAX_SHIFT) ? m_pend : MAX_SHIFT;
      consume(a);
      m_pend = add_sat(m_pend - a + live);
      m_mode = (m_pend == 0) ? 0 : 2;
    end
  endtask

  function automatic logic [DATA_W-1:0] m_out_data();
    logic [DATA_W-1:0] r = '0;
    for (int i = 0; i < DATA_SYMS && i < q.size(); i++) r[SYM_W*i +: SYM_W] = 2'(q[i]);
    return r;
  endfunction

  function automatic bit m_in_ready();
    return (m_mode == 0) && !stall && (q.size() <= TAIL_SYMS);
  endfunction

  function automatic bit m_out_valid();
    return (m_mode == 0) && !stall && (q.size() >= DATA_SYMS);
  endfunction

  // Advance one clock: DUT and model both see the inputs held across the edge.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle_inputs();
    in_valid  = 1'b0;
    shift_req = 1'b0;
    shift_amt = '0;
    stall     = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  function automatic logic [DATA_W-1:0] rand_block();
    logic [DATA_W-1:0] r;
    for (int i = 0; i < DATA_W / 32; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  task automatic load_block(input logic [DATA_W-1:0] blk);
    in_data  = blk;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    n_checks++; if (out_data !== '0) begin n_errors++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
    n_checks++; if (avail !== '0) begin n_errors++; $display("FAIL reset_avail got=%0d exp=0", avail); end
    n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    n_checks++; if (in_ready !== 1'b1) begin n_errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    n_checks++; if ({pend_cnt, underflow, pend_ovf} !== '0) begin n_errors++; $display("FAIL reset_pend got=%0d/%b/%b exp=0/0/0", pend_cnt, underflow, pend_ovf); end
    rst = 1'b0;
  endtask

  task automatic test_load_shift();
    logic [DATA_W-1:0] a, b;
    a = rand_block();
    b = rand_block();
    do_reset();
    load_block(a);
    n_checks++; if (avail !== 9'd256) begin n_errors++; $display("FAIL load_avail got=%0d exp=256", avail); end
    n_checks++; if (out_data !== a) begin n_errors++; $display("FAIL load_data got=%h exp=%h", out_data, a); end
    n_checks++; if ({out_valid, in_ready} !== 2'b10) begin n_errors++; $display("FAIL load_flags got=%b%b exp=10", out_valid, in_ready); end
    shift_req = 1'b1;
    shift_amt = 3'd1;
    repeat (246) tick();
    n_checks++; if (avail !== 9'd10) begin n_errors++; $display("FAIL drain_avail got=%0d exp=10", avail); end
    n_checks++; if (in_ready !== 1'b1) begin n_errors++; $display("FAIL drain_in_ready got=%b exp=1", in_ready); end
    shift_amt = 3'd2;
    in_data   = b;
    in_valid  = 1'b1;
    tick();
    idle_inputs();
    n_checks++; if (avail !== 9'd264) begin n_errors++; $display("FAIL append_avail got=%0d exp=264", avail); end
    n_checks++; if (out_data !== {b[495:0], a[511:496]}) begin n_errors++; $display("FAIL append_data got=%h exp=%h", out_data, {b[495:0], a[511:496]}); end
  endtask

  task automatic test_stall_catchup();
    logic [DATA_W-1:0] a;
    int exp_av[4] = '{252, 248, 244, 241};
    a = rand_block();
    do_reset();
    load_block(a);
    stall     = 1'b1;
    shift_req = 1'b1;
    shift_amt = 3'd3;
    repeat (5) tick();
    n_checks++; if (pend_cnt !== 9'd15) begin n_errors++; $display("FAIL stall_pend got=%0d exp=15", pend_cnt); end
    n_checks++; if (out_data !== a || avail !== 9'd256) begin n_errors++; $display("FAIL stall_frozen got=%0d exp=256", avail); end
    n_checks++; if ({out_valid, in_ready} !== 2'b00) begin n_errors++; $display("FAIL stall_flags got=%b%b exp=00", out_valid, in_ready); end
    idle_inputs();
    tick();
    for (int k = 0; k < 4; k++) begin
      tick();
      n_checks++; if (avail !== AV_W'(exp_av[k])) begin n_errors++; $display("FAIL catchup_avail step=%0d got=%0d exp=%0d", k, avail, exp_av[k]); end
    end
    n_checks++; if (pend_cnt !== '0 || out_valid !== 1'b0) begin n_errors++; $display("FAIL catchup_end got=%0d/%b exp=0/0", pend_cnt, out_valid); end
    n_checks++; if (out_data !== (a >> 30)) begin n_errors++; $display("FAIL catchup_data got=%h exp=%h", out_data, a >> 30); end
  endtask

  task automatic test_underflow();
    do_reset();
    load_block(rand_block());
    shift_req = 1'b1;
    shift_amt = 3'd4;
    repeat (63) tick();
    shift_amt = 3'd2;
    tick();
    n_checks++; if (avail !== 9'd2) begin n_errors++; $display("FAIL uf_setup_avail got=%0d exp=2", avail); end
    shift_amt = 3'd4;
    tick();
    n_checks++; if (avail !== '0 || out_data !== '0) begin n_errors++; $display("FAIL uf_clear got=%0d exp=0", avail); end
    n_checks++; if (underflow !== 1'b1) begin n_errors++; $display("FAIL uf_pulse got=%b exp=1", underflow); end
    shift_req = 1'b0;
    tick();
    n_checks++; if (underflow !== 1'b0) begin n_errors++; $display("FAIL uf_one_cycle got=%b exp=0", underflow); end
  endtask

  task automatic test_pend_ovf();
    do_reset();
    load_block(rand_block());
    stall     = 1'b1;
    shift_req = 1'b1;
    shift_amt = 3'd4;
    repeat (130) tick();
    n_checks++; if (pend_cnt !== 9'd511 || pend_ovf !== 1'b1) begin n_errors++; $display("FAIL ovf_sat got=%0d/%b exp=511/1", pend_cnt, pend_ovf); end
    idle_inputs();
    repeat (3) tick();
    n_checks++; if (pend_ovf !== 1'b1 || pend_cnt !== 9'd503) begin n_errors++; $display("FAIL ovf_sticky got=%0d/%b exp=503/1", pend_cnt, pend_ovf); end
    n_checks++; if (in_ready !== 1'b0) begin n_errors++; $display("FAIL catchup_no_load got=%b exp=0", in_ready); end
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    n_checks++; if (pend_cnt !== '0 || avail !== '0 || pend_ovf !== 1'b0) begin n_errors++; $display("FAIL async_rst got=%0d/%0d/%b exp=0/0/0", pend_cnt, avail, pend_ovf); end
    n_checks++; if (in_ready !== 1'b1) begin n_errors++; $display("FAIL async_rst_ready got=%b exp=1", in_ready); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_catchup_live();
    logic [DATA_W-1:0] a;
    a = rand_block();
    do_reset();
    load_block(a);
    stall     = 1'b1;
    shift_req = 1'b1;
    shift_amt = 3'd3;
    repeat (2) tick();
    idle_inputs();
    tick();
    n_checks++; if (pend_cnt !== 9'd6) begin n_errors++; $display("FAIL live_pend0 got=%0d exp=6", pend_cnt); end
    shift_req = 1'b1;
    shift_amt = 3'd2;
    tick();
    shift_req = 1'b0;
    n_checks++; if (pend_cnt !== 9'd4 || avail !== 9'd252) begin n_errors++; $display("FAIL live_pend1 got=%0d/%0d exp=4/252", pend_cnt, avail); end
    tick();
    n_checks++; if (pend_cnt !== '0 || avail !== 9'd248) begin n_errors++; $display("FAIL live_pend2 got=%0d/%0d exp=0/248", pend_cnt, avail); end
    n_checks++; if (out_data !== (a >> 16)) begin n_errors++; $display("FAIL live_data got=%h exp=%h", out_data, a >> 16); end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      in_data   = rand_block();
      in_valid  = ($urandom_range(0, 1) == 1);
      shift_req = ($urandom_range(0, 3) != 0);
      shift_amt = 3'($urandom_range(0, MAX_SHIFT));
      if ($urandom_range(0, 7) == 0) stall = ~stall;
      tick();
      n_checks++; if (avail !== AV_W'(q.size())) begin n_errors++; $display("FAIL rnd_avail cyc=%0d got=%0d exp=%0d", c, avail, q.size()); end
      n_checks++; if (out_data !== m_out_data()) begin n_errors++; $display("FAIL rnd_data cyc=%0d got=%h exp=%h", c, out_data, m_out_data()); end
      n_checks++; if (out_valid !== m_out_valid()) begin n_errors++; $display("FAIL rnd_out_valid cyc=%0d got=%b exp=%b", c, out_valid, m_out_valid()); end
      n_checks++; if (in_ready !== m_in_ready()) begin n_errors++; $display("FAIL rnd_in_ready cyc=%0d got=%b exp=%b", c, in_ready, m_in_ready()); end
      n_checks++; if (pend_cnt !== CNT_W'(m_pend)) begin n_errors++; $display("FAIL rnd_pend cyc=%0d got=%0d exp=%0d", c, pend_cnt, m_pend); end
      n_checks++; if (underflow !== m_uf) begin n_errors++; $display("FAIL rnd_underflow cyc=%0d got=%b exp=%b", c, underflow, m_uf); end
      n_checks++; if (pend_ovf !== m_ovf) begin n_errors++; $display("FAIL rnd_ovf cyc=%0d got=%b exp=%b", c, pend_ovf, m_ovf); end
    end
    idle_inputs();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_load_shift();
    test_stall_catchup();
    test_underflow();
    test_pend_ovf();
    test_catchup_live();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/seq_shift_window.md
Name: seq_shift_window

Overview:
Parametrised successor to the 2-bit nucleotide shift register in the BLAST query/database datapath. Holds a window of packed symbols. Accepts full data blocks through a valid/ready handshake and appends each new block above the unconsumed tail symbols. Consumes a variable number of symbols per cycle (1..MAX_SHIFT). Shifts requested during a stall are accumulated and replayed in a bounded catch-up phase, so no shift is lost.

Parameters:
DATA_W, 512, width of one input block and of out_data (bits)
SYM_W, 2, bits per symbol (2 = nucleotide)
TAIL_SYMS, 11, extra symbols of headroom kept below a newly loaded block
MAX_SHIFT, 4, maximum symbols consumed per cycle
CNT_W, 9, width of the pending-shift accumulator

Derived values:
- DATA_SYMS = DATA_W/SYM_W
- REG_SYMS = DATA_SYMS + TAIL_SYMS
- AMT_W = $clog2(MAX_SHIFT+1)
- AV_W = $clog2(REG_SYMS+1)

Ports:
clk  in  1  clock; all state on rising edge
rst  in  1  asynchronous, active-high reset
in_data  in  DATA_W  block to load; symbol 0 in bits [SYM_W-1:0]
in_valid  in  1  in_data valid
in_ready  out  1  block can be accepted this cycle
shift_req  in  1  consume shift_amt symbols
shift_amt  in  AMT_W  symbols to consume, 0..MAX_SHIFT
stall  in  1  downstream stall; defer shifts and block loads
out_data  out  DATA_W  low DATA_W bits of the window
out_valid  out  1  window holds at least DATA_SYMS valid symbols
avail  out  AV_W  count of valid symbols in the window
pend_cnt  out  CNT_W  accumulated deferred shifts
underflow  out  1  one-cycle pulse: a shift exceeded avail
pend_ovf  out  1  sticky: pend accumulator saturated

Behaviour:
- Storage: win[REG_SYMS*SYM_W-1:0] and avail. Bits at and above avail*SYM_W are always zero.
- Reset (async, asserted): win=0, avail=0, pend_cnt=0, state=RUN, underflow=0, pend_ovf=0. Resulting outputs: out_data=0, out_valid=0, in_ready=1.
- States:
  - RUN: normal operation. Goes to HOLD while stall=1.
  - HOLD: entered from RUN on stall=1. Returns to RUN when stall=0 and pend_cnt=0. Goes to CATCHUP when stall=0 and pend_cnt>0.
  - CATCHUP: entered from HOLD as above. Goes back to HOLD if stall=1. Goes to RUN once pend_cnt reaches 0.
- Stall timing: stall is combinational into all gating. In the cycle stall rises, RUN behaves as HOLD.
- in_ready = (state==RUN) & !stall & (avail <= TAIL_SYMS), computed from registered avail.
- out_valid = (state==RUN) & !stall & (avail >= DATA_SYMS).
- RUN shift: shift_req with amt<=avail gives win >>= amt*SYM_W (zero-filled) and avail -= amt. amt=0 is a no-op.
- RUN underflow: shift_req with amt>avail gives win=0, avail=0, and underflow=1 for the next cycle only.
- RUN load: on in_valid & in_ready, the block is written at bit offset avail'*SYM_W, where avail' is avail after any same-cycle shift. Then avail = avail' + DATA_SYMS.
- Simultaneous load and shift: the shift applies to the old contents first, then the append happens. in_ready uses the pre-shift avail.
- HOLD: win and avail frozen. shift_req adds shift_amt to pend_cnt, saturating at 2^CNT_W-1. Saturation sets pend_ovf, which stays set until reset.
- CATCHUP, each cycle:
  - a = min(pend_cnt, MAX_SHIFT).
  - Apply the RUN shift rule with a, including the underflow rule.
  - pend_cnt = pend_cnt - a + (shift_req ? shift_amt : 0), saturating.
  - No loads (in_ready=0), out_valid=0.
- Replay bound: deferred shifts are replayed at no more than MAX_SHIFT symbols per cycle. Ordering relative to live shifts is preserved because live shifts during CATCHUP are added to pend_cnt.
- Latency: all outputs are registered, or combinational from registered state plus stall. A load or shift is visible on out_data/avail on the cycle after the accepting edge.
- Async reset mid-load or mid-CATCHUP: all state clears immediately, and pending shifts are discarded.

Test Plan (defaults: DATA_SYMS=256, REG_SYMS=267):
1. Reset, then in_data=A with in_valid for 1 cycle → next cycle avail=256, out_data=A, out_valid=1, in_ready=0.
2. After 1, shift_amt=1 for 246 cycles → avail=10, in_ready=1. Then load B with shift_amt=2 in the same cycle → avail=264, out_data={B[495:0],A[511:496]}.
3. From avail=256, stall=1 for 5 cycles with shift_amt=3 → pend_cnt=15, win unchanged. Release stall → CATCHUP shifts of 4,4,4,3 over 4 cycles, then RUN with avail=241 and out_valid=0.
4. avail=2, shift_amt=4 in RUN → avail=0, out_data=0, underflow high for exactly 1 cycle.
5. Stall for 130 cycles with shift_amt=4 → pend_cnt=511, pend_ovf=1 and staying set. Assert rst mid-CATCHUP → same cycle pend_cnt=0, avail=0, pend_ovf=0, state RUN.
6. In CATCHUP with pend_cnt=6, shift_req=1 with shift_amt=2 → pend_cnt sequence 6, 4, 0. Window consumes 8 symbols total.
